// File: rtl/rtc_regbank_mp_if.sv
// Bus bundle for rtc_regbank_mp: write port, NRD read ports and copy/clear engine control.
interface rtc_regbank_mp_if #(
    parameter int DW  = 8,
    parameter int AW  = 4,
    parameter int NRD = 3
);
    logic              wr_en;
    logic [1:0]        wr_bank;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic [NRD-1:0]    rd_en;
    logic [2*NRD-1:0]  rd_bank;
    logic [AW*NRD-1:0] rd_addr;
    logic [DW*NRD-1:0] rd_data;
    logic [NRD-1:0]    rd_valid;
    logic              cp_start;
    logic              cp_op;
    logic [1:0]        cp_src;
    logic [1:0]        cp_dst;
    logic              cp_busy;
    logic              cp_done;
    logic              cp_err;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
               cp_start, cp_op, cp_src, cp_dst,
        input  wr_ready, rd_data, rd_valid, cp_busy, cp_done, cp_err
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
               cp_start, cp_op, cp_src, cp_dst,
        output wr_ready, rd_data, rd_valid, cp_busy, cp_done, cp_err
    );
endinterface

// File: rtl/rtc_regbank_mp.sv
// Multi-bank RTC register file: one write port, NRD registered read ports and a
// bank copy/clear engine that walks one word per cycle.
module rtc_regbank_mp #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int NBANK = 3,
    parameter int NRD   = 3
) (
    input  logic            clk,
    input  logic            reset,
    rtc_regbank_mp_if.slave bus
);
    localparam int            NW       = 2 ** AW;
    localparam logic [2:0]    NBANK_W  = 3'(NBANK);
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_W   = {DW{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state_r;
    state_t            state_s;
    logic [AW-1:0]     idx_r;
    logic              op_r;
    logic [1:0]        src_r;
    logic [1:0]        dst_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              wr_ready_r;
    logic              err_s;
    logic              start_ok_s;
    logic              wr_fire_s;
    logic [DW-1:0]     mem_r [NBANK][NW];
    logic [DW-1:0]     rd_word_s [NRD];
    logic [DW*NRD-1:0] rd_data_r;
    logic [NRD-1:0]    rd_valid_r;

    function automatic logic bank_ok(input logic [1:0] bank);
        return ({1'b0, bank} < NBANK_W);
    endfunction

    // Engine next-state and start validation.
    always_comb begin
        state_s    = state_r;
        err_s      = 1'b0;
        start_ok_s = bank_ok(bus.cp_dst) && (bus.cp_op || bank_ok(bus.cp_src));
        case (state_r)
            IDLE: begin
                if (bus.cp_start) begin
                    if (start_ok_s) begin
                        state_s = RUN;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == IDX_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Engine state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Engine operands, word index and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r       <= 1'b0;
            src_r      <= 2'd0;
            dst_r      <= 2'd0;
            idx_r      <= {AW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            busy_r     <= (state_s == RUN);
            done_r     <= (state_s == DONE);
            err_r      <= err_s;
            wr_ready_r <= (state_s != RUN);
            if (state_r == IDLE && state_s == RUN) begin
                op_r  <= bus.cp_op;
                // A clear never reads its source, so park it on a bank that exists.
                src_r <= bus.cp_op ? 2'd0 : bus.cp_src;
                dst_r <= bus.cp_dst;
                idx_r <= {AW{1'b0}};
            end else if (state_r == RUN) begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

    // Write-port acceptance.
    always_comb begin
        wr_fire_s = bus.wr_en & wr_ready_r & bank_ok(bus.wr_bank);
    end

    // Storage: engine writes and port writes are mutually exclusive via wr_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int w = 0; w < NW; w++) begin
                    mem_r[b][w] <= ZERO_W;
                end
            end
        end else if (state_r == RUN) begin
            mem_r[dst_r][idx_r] <= op_r ? ZERO_W : mem_r[src_r][idx_r];
        end else if (wr_fire_s) begin
            mem_r[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read-port word select; invalid banks read as zero.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            if (bank_ok(bus.rd_bank[2*i +: 2])) begin
                rd_word_s[i] = mem_r[bus.rd_bank[2*i +: 2]][bus.rd_addr[AW*i +: AW]];
            end else begin
                rd_word_s[i] = ZERO_W;
            end
        end
    end

    // Registered read ports; data holds while a port is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= {(DW*NRD){1'b0}};
            rd_valid_r <= {NRD{1'b0}};
        end else begin
            rd_valid_r <= bus.rd_en;
            for (int i = 0; i < NRD; i++) begin
                if (bus.rd_en[i]) begin
                    rd_data_r[DW*i +: DW] <= rd_word_s[i];
                end
            end
        end
    end

    assign bus.wr_ready = wr_ready_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.cp_busy  = busy_r;
    assign bus.cp_done  = done_r;
    assign bus.cp_err   = err_r;
endmodule

// File: tb/tb_rtc_regbank_mp.sv
// Scoreboard bench for rtc_regbank_mp: stimulus pushes expected responses from a
// word-array model, a negedge monitor pops and compares what the DUT presents.
module tb_rtc_regbank_mp;
    localparam int DW = 8, AW = 4, NBANK = 3, NRD = 3, NW = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          rst_q      = 1'b1;
    int            cyc        = 0;
    int            checks     = 0;
    int            errors     = 0;
    logic [DW-1:0] mdl [4][NW];
    rd_exp_t       rq [NRD][$];
    int            done_q [$];
    int            err_q [$];
    logic [DW-1:0] last_rd [NRD];
    logic          eng_active = 1'b0;
    int            eng_s      = 0;
    logic [1:0]    eng_dst    = 2'd0;

    rtc_regbank_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    rtc_regbank_mp #(.DW(DW), .AW(AW), .NBANK(NBANK), .NRD(NRD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Engine windows relative to an accepted start at cycle eng_s.
    function automatic logic blocks_start(int n);
        return eng_active && n >= eng_s + 1 && n <= eng_s + 17;
    endfunction
    function automatic logic blocks_write(int n);
        return eng_active && n >= eng_s + 1 && n <= eng_s + 16;
    endfunction
    function automatic logic dst_locked(logic [1:0] b, int n);
        return eng_active && b == eng_dst && n >= eng_s && n <= eng_s + 16;
    endfunction

    // Monitor: pops expected responses and tracks engine status each cycle.
    always @(negedge clk) begin
        rd_exp_t e;
        logic    exp_busy;
        if (rst_q) begin
            for (int i = 0; i < NRD; i++) begin
                rq[i].delete();
                last_rd[i] = '0;
            end
            done_q.delete();
            err_q.delete();
            chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
            chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
            chk("rst_busy", 32'(bus.cp_busy), 32'd0);
            chk("rst_done", 32'(bus.cp_done), 32'd0);
            chk("rst_err", 32'(bus.cp_err), 32'd0);
            chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        end else begin
            for (int i = 0; i < NRD; i++) begin
                while (rq[i].size() > 0 && rq[i][0].due < cyc) begin
                    chk($sformatf("rd%0d_missing_valid", i), 32'd0, 32'd1);
                    void'(rq[i].pop_front());
                end
                if (bus.rd_valid[i]) begin
                    if (rq[i].size() == 0) begin
                        chk($sformatf("rd%0d_unexpected_valid", i), 32'd1, 32'd0);
                    end else begin
                        e = rq[i].pop_front();
                        chk($sformatf("rd%0d_latency", i), 32'(cyc), 32'(e.due));
                        chk($sformatf("rd%0d_data", i), 32'(bus.rd_data[DW*i +: DW]), 32'(e.data));
                        last_rd[i] = e.data;
                    end
                end else begin
                    chk($sformatf("rd%0d_hold", i), 32'(bus.rd_data[DW*i +: DW]), 32'(last_rd[i]));
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                chk("cp_done_missing", 32'd0, 32'd1);
                void'(done_q.pop_front());
            end
            if (bus.cp_done) begin
                if (done_q.size() == 0) chk("cp_done_unexpected", 32'd1, 32'd0);
                else chk("cp_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
                chk("cp_err_missing", 32'd0, 32'd1);
                void'(err_q.pop_front());
            end
            if (bus.cp_err) begin
                if (err_q.size() == 0) chk("cp_err_unexpected", 32'd1, 32'd0);
                else chk("cp_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
            if (!reset) begin
                exp_busy = blocks_write(cyc);
                chk("cp_busy", 32'(bus.cp_busy), 32'(exp_busy));
                chk("wr_ready", 32'(bus.wr_ready), 32'(!exp_busy));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rd_en    = '0;
        bus.wr_en    = 1'b0;
        bus.cp_start = 1'b0;
    endtask

    task automatic do_read(int p, logic [1:0] b, logic [AW-1:0] a);
        rd_exp_t e;
        bus.rd_en[p]          = 1'b1;
        bus.rd_bank[2*p +: 2] = b;
        bus.rd_addr[AW*p +: AW] = a;
        e.data = (int'(b) < NBANK) ? mdl[b][a] : 8'h00;
        e.due  = cyc + 1;
        rq[p].push_back(e);
    endtask

    task automatic do_write(logic [1:0] b, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_bank = b;
        bus.wr_addr = a;
        bus.wr_data = d;
        if (!blocks_write(cyc) && int'(b) < NBANK) mdl[b][a] = d;
    endtask

    task automatic do_start(logic op, logic [1:0] src, logic [1:0] dst);
        bus.cp_start = 1'b1;
        bus.cp_op    = op;
        bus.cp_src   = src;
        bus.cp_dst   = dst;
        if (!blocks_start(cyc)) begin
            if (int'(dst) < NBANK && (op || int'(src) < NBANK)) begin
                eng_active = 1'b1;
                eng_s      = cyc;
                eng_dst    = dst;
                done_q.push_back(cyc + 17);
                for (int w = 0; w < NW; w++) mdl[dst][w] = op ? 8'h00 : mdl[src][w];
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic read_all_banks();
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < NW; a++) begin
                do_read((a + b) % NRD, 2'(b), 4'(a));
                tick();
            end
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_bank = 2'd0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = '0; bus.rd_bank = '0; bus.rd_addr = '0;
        bus.cp_start = 1'b0; bus.cp_op = 1'b0; bus.cp_src = 2'd0; bus.cp_dst = 2'd0;
        for (int b = 0; b < 4; b++) for (int w = 0; w < NW; w++) mdl[b][w] = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: everything reads zero after reset, all ports
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < NW; a++) begin
                for (int p = 0; p < NRD; p++) do_read(p, 2'(b), 4'(a));
                tick();
            end
        end

        // 2: write then read, read-before-write collision
        do_write(2'd0, 4'd5, 8'h3B); tick();
        do_read(1, 2'd0, 4'd5); tick();
        do_read(1, 2'd0, 4'd5); do_write(2'd0, 4'd5, 8'h44); tick();
        do_read(1, 2'd0, 4'd5); tick();
        tick();

        // 3: fill bank0, copy 0->1, reads of bank0 while busy
        for (int a = 0; a < NW; a++) begin do_write(2'd0, 4'(a), 8'(a + 16)); tick(); end
        do_start(1'b0, 2'd0, 2'd1); tick();
        for (int k = 0; k < 18; k++) begin do_read(0, 2'd0, 4'(k)); tick(); end
        read_all_banks();

        // 4: fill bank2, clear it, writes to bank2 while busy are dropped
        for (int a = 0; a < NW; a++) begin do_write(2'd2, 4'(a), 8'hFF); tick(); end
        do_start(1'b1, 2'd0, 2'd2); tick();
        for (int k = 0; k < 16; k++) begin do_write(2'd2, 4'(k), 8'h5A); tick(); end
        read_all_banks();

        // 5: rejected starts, same-bank copy, ignored starts while busy/done
        do_start(1'b0, 2'd0, 2'd3); tick(); tick();
        do_start(1'b0, 2'd3, 2'd0); tick(); tick();
        do_start(1'b0, 2'd1, 2'd1); tick();
        for (int k = 1; k <= 17; k++) begin
            if (k == 3 || k == 17) do_start(1'b1, 2'd0, 2'd0);
            tick();
        end
        tick();
        read_all_banks();
        do_start(1'b1, 2'd3, 2'd0); tick();
        repeat (18) tick();
        read_all_banks();

        // 6: reset in the middle of a copy
        for (int a = 0; a < NW; a++) begin do_write(2'd0, 4'(a), 8'($urandom_range(1, 255))); tick(); end
        do_start(1'b0, 2'd0, 2'd1); tick();
        repeat (7) tick();
        reset = 1'b1;
        eng_active = 1'b0;
        for (int b = 0; b < 4; b++) for (int w = 0; w < NW; w++) mdl[b][w] = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        repeat (20) tick();
        read_all_banks();

        // 7: randomised traffic on every port and the engine
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NRD; p++) begin
                logic [1:0] b;
                b = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1 && !dst_locked(b, cyc)) do_read(p, b, 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 2) == 0)
                do_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 24) == 0)
                do_start(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
        end
        repeat (20) tick();
        read_all_banks();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
